// File: rtl/alu_writeback_stage_if.sv
// alu_writeback_stage_if: handshake, carry and trap signals between the arithmetic unit, the writeback stage and its consumers.
interface alu_writeback_stage_if #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_carry;
    logic              in_div_by_zero;
    logic [RD_W-1:0]   in_rd;
    logic              in_writes_rd;
    logic              in_writes_carry;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_writes_rd;
    logic              carry_flag;
    logic              trap_pending;
    logic [RD_W-1:0]   trap_rd;
    logic              trap_ack;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output in_valid, in_result, in_carry, in_div_by_zero, in_rd, in_writes_rd, in_writes_carry,
        output out_ready, trap_ack,
        input  in_ready, out_valid, out_result, out_rd, out_writes_rd,
        input  carry_flag, trap_pending, trap_rd, retired_count
    );

    modport slave (
        input  in_valid, in_result, in_carry, in_div_by_zero, in_rd, in_writes_rd, in_writes_carry,
        input  out_ready, trap_ack,
        output in_ready, out_valid, out_result, out_rd, out_writes_rd,
        output carry_flag, trap_pending, trap_rd, retired_count
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: registers arithmetic results into a 2-entry skid buffer toward writeback,
// owns the architectural carry flag and turns divide-by-zero into a held trap request.
module alu_writeback_stage #(
    parameter int DATA_W = 64,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 32
) (
    input logic clk,
    input logic rst_n,
    alu_writeback_stage_if.slave bus
);
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_result;
    logic [RD_W-1:0]   r_out_rd;
    logic              r_out_writes_rd;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_result;
    logic [RD_W-1:0]   r_skid_rd;
    logic              r_skid_writes_rd;
    logic              r_carry;
    logic              r_trap_pending;
    logic [RD_W-1:0]   r_trap_rd;
    logic [CNT_W-1:0]  r_count;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_enq;
    logic              w_trap;
    logic              w_drain;

    // ready depends only on registers, so no in_valid/out_ready path reaches it
    assign w_in_ready = !r_skid_valid && !r_trap_pending;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_enq      = w_accept && !bus.in_div_by_zero;
    assign w_trap     = w_accept && bus.in_div_by_zero;
    assign w_drain    = r_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid      <= 1'b0;
            r_out_result     <= '0;
            r_out_rd         <= '0;
            r_out_writes_rd  <= 1'b0;
            r_skid_valid     <= 1'b0;
            r_skid_result    <= '0;
            r_skid_rd        <= '0;
            r_skid_writes_rd <= 1'b0;
            r_carry          <= 1'b0;
            r_trap_pending   <= 1'b0;
            r_trap_rd        <= '0;
            r_count          <= '0;
        end else begin
            if (w_drain) begin
                if (r_skid_valid) begin
                    r_out_result    <= r_skid_result;
                    r_out_rd        <= r_skid_rd;
                    r_out_writes_rd <= r_skid_writes_rd;
                    r_skid_valid    <= 1'b0;
                end else if (w_enq) begin
                    r_out_result    <= bus.in_result;
                    r_out_rd        <= bus.in_rd;
                    r_out_writes_rd <= bus.in_writes_rd;
                end else begin
                    r_out_valid     <= 1'b0;
                end
            end else if (!r_out_valid) begin
                if (w_enq) begin
                    r_out_valid     <= 1'b1;
                    r_out_result    <= bus.in_result;
                    r_out_rd        <= bus.in_rd;
                    r_out_writes_rd <= bus.in_writes_rd;
                end
            end else if (w_enq) begin
                r_skid_valid     <= 1'b1;
                r_skid_result    <= bus.in_result;
                r_skid_rd        <= bus.in_rd;
                r_skid_writes_rd <= bus.in_writes_rd;
            end
            // carry moves at acceptance so the very next op already sees it
            if (w_enq && bus.in_writes_carry)
                r_carry <= bus.in_carry;
            if (w_trap) begin
                r_trap_pending <= 1'b1;
                r_trap_rd      <= bus.in_rd;
            end else if (bus.trap_ack) begin
                r_trap_pending <= 1'b0;
            end
            if (w_drain)
                r_count <= r_count + 1'b1;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_result    = r_out_result;
    assign bus.out_rd        = r_out_rd;
    assign bus.out_writes_rd = r_out_writes_rd;
    assign bus.carry_flag    = r_carry;
    assign bus.trap_pending  = r_trap_pending;
    assign bus.trap_rd       = r_trap_rd;
    assign bus.retired_count = r_count;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: vector table plus hand sequences, with a scoreboard on the writeback output.
module tb_alu_writeback_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    int n_pushed = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wr;
        logic        wc;
        logic        cin;
        logic        exp_carry;
    } vec_t;

    exp_t q[$];
    vec_t vt[6];

    alu_writeback_stage_if #(.DATA_W(64), .RD_W(5), .CNT_W(4)) bus();

    alu_writeback_stage #(.DATA_W(64), .RD_W(5), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_bound(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired", nm);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_out: got result %h rd %0d with empty scoreboard", bus.out_result, bus.out_rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
                chk("out_writes_rd", 64'(bus.out_writes_rd), 64'(e.wr));
            end
        end
    end

    task automatic send(input logic [63:0] res, input logic [4:0] rd, input logic wr, input logic wc,
                        input logic cin, input logic dbz);
        bit ok;
        @(posedge clk); #1;
        bus.in_result = res;
        bus.in_rd = rd;
        bus.in_writes_rd = wr;
        bus.in_writes_carry = wc;
        bus.in_carry = cin;
        bus.in_div_by_zero = dbz;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) fail_bound("send_accept");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (ok && !dbz) begin
            q.push_back('{res, rd, wr});
            n_pushed++;
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1;
        bus.out_ready = v;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) fail_bound("drain");
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        n_pushed = 0;
        @(negedge clk);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_out_result"}, bus.out_result, 64'd0);
        chk({tag, "_out_rd"}, 64'(bus.out_rd), 64'd0);
        chk({tag, "_out_writes_rd"}, 64'(bus.out_writes_rd), 64'd0);
        chk({tag, "_carry"}, 64'(bus.carry_flag), 64'd0);
        chk({tag, "_trap_pending"}, 64'(bus.trap_pending), 64'd0);
        chk({tag, "_trap_rd"}, 64'(bus.trap_rd), 64'd0);
        chk({tag, "_count"}, 64'(bus.retired_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{64'h10, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[1] = '{64'h20, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{64'h30, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[4] = '{64'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{64'h8000_0000_0000_0000, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        bus.in_carry = 1'b0;
        bus.in_div_by_zero = 1'b0;
        bus.in_rd = '0;
        bus.in_writes_rd = 1'b0;
        bus.in_writes_carry = 1'b0;
        bus.out_ready = 1'b0;
        bus.trap_ack = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("rst0");

        set_ready(1'b1);
        send(64'h2A, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_out_result", bus.out_result, 64'h2A);
        chk("lat_out_rd", 64'(bus.out_rd), 64'd3);
        @(negedge clk);
        chk("lat_count", 64'(bus.retired_count), 64'd1);

        set_ready(1'b0);
        send(64'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(64'd2, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.in_result = 64'd3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("skid_full_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_hold_result", bus.out_result, 64'd1);
        end
        bus.in_valid = 1'b0;
        set_ready(1'b1);
        send(64'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("skid_drained_valid", 64'(bus.out_valid), 64'd0);

        for (int i = 0; i < 6; i++) begin
            send(vt[i].res, vt[i].rd, vt[i].wr, vt[i].wc, vt[i].cin, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_carry", i), 64'(bus.carry_flag), 64'(vt[i].exp_carry));
        end
        wait_drain();

        set_ready(1'b0);
        send(64'h55, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        send(64'hDEAD, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("trap_pending", 64'(bus.trap_pending), 64'd1);
        chk("trap_rd", 64'(bus.trap_rd), 64'd7);
        chk("trap_carry_held", 64'(bus.carry_flag), 64'd0);
        chk("trap_in_ready", 64'(bus.in_ready), 64'd0);
        chk("trap_out_held", bus.out_result, 64'h55);
        set_ready(1'b1);
        wait_drain();
        chk("trap_no_out", 64'(bus.out_valid), 64'd0);
        chk("trap_still_pending", 64'(bus.trap_pending), 64'd1);
        @(posedge clk); #1;
        bus.trap_ack = 1'b1;
        @(posedge clk); #1;
        bus.trap_ack = 1'b0;
        @(negedge clk);
        chk("ack_trap_pending", 64'(bus.trap_pending), 64'd0);
        chk("ack_in_ready", 64'(bus.in_ready), 64'd1);
        chk("ack_trap_rd_hold", 64'(bus.trap_rd), 64'd7);
        @(posedge clk); #1;
        bus.trap_ack = 1'b1;
        @(posedge clk); #1;
        bus.trap_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_pending", 64'(bus.trap_pending), 64'd0);

        while (n_pushed % 16 != 15)
            send(64'(n_pushed), 5'(n_pushed), 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("count_15", 64'(bus.retired_count), 64'd15);
        send(64'hF00D, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("count_wrap", 64'(bus.retired_count), 64'd0);

        set_ready(1'b0);
        send(64'hAA, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        send(64'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("pre_rst_trap", 64'(bus.trap_pending), 64'd1);
        chk("pre_rst_carry", 64'(bus.carry_flag), 64'd1);
        do_reset("rst_trap");

        send(64'hB1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        send(64'hB2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_skid_full", 64'(bus.in_ready), 64'd0);
        do_reset("rst_skid");
        set_ready(1'b1);
        send(64'hC3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        chk("post_rst_count", 64'(bus.retired_count), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
